// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// datapath mux selects and the control-strobe bundle.
package mc_pkg;

   typedef enum logic [3:0] {
      ST_FETCH     = 4'd0,
      ST_DECODE    = 4'd1,
      ST_MEM_ADDR  = 4'd2,
      ST_MEM_READ  = 4'd3,
      ST_MEM_WB    = 4'd4,
      ST_MEM_WRITE = 4'd5,
      ST_R_EXEC    = 4'd6,
      ST_R_WB      = 4'd7,
      ST_I_EXEC    = 4'd8,
      ST_I_WB      = 4'd9,
      ST_BRANCH    = 4'd10,
      ST_JUMP      = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond_eq;
      logic       pc_write_cond_ne;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       illegal_op;
   } ctrl_t;

   // True in the final cycle of every legal instruction.
   function automatic logic retires(input state_t s, input logic mem_ready);
      case (s)
         ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP: return 1'b1;
         ST_MEM_WRITE: return mem_ready;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Combinational next-state and control-strobe decode for the multicycle
// controller; the state register lives in the top level.
module mc_out_decode
   import mc_pkg::*;
(
   input  state_t     state,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output state_t     next_state,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl       = '0;
      next_state = state;
      case (state)
         ST_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
            if (mem_ready) next_state = ST_DECODE;
         end
         ST_DECODE: begin
            // Branch target is computed here speculatively into ALUOut.
            ctrl.alu_src_b = SRCB_IMM_SL2;
            case (opcode)
               OP_LW, OP_SW:   next_state = ST_MEM_ADDR;
               OP_RTYPE:       next_state = ST_R_EXEC;
               OP_BEQ, OP_BNE: next_state = ST_BRANCH;
               OP_ADDI:        next_state = ST_I_EXEC;
               OP_J:           next_state = ST_JUMP;
               default: begin
                  ctrl.illegal_op = 1'b1;
                  next_state      = ST_FETCH;
               end
            endcase
         end
         ST_MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            next_state     = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
         end
         ST_MEM_READ: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
            if (mem_ready) next_state = ST_MEM_WB;
         end
         ST_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            next_state      = ST_FETCH;
         end
         ST_MEM_WRITE: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
            if (mem_ready) next_state = ST_FETCH;
         end
         ST_R_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALUOP_FUNCT;
            next_state     = ST_R_WB;
         end
         ST_R_WB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
            next_state     = ST_FETCH;
         end
         ST_I_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            next_state     = ST_I_WB;
         end
         ST_I_WB: begin
            ctrl.reg_write = 1'b1;
            next_state     = ST_FETCH;
         end
         ST_BRANCH: begin
            ctrl.alu_src_a        = 1'b1;
            ctrl.alu_src_b        = SRCB_REG;
            ctrl.alu_op           = ALUOP_SUB;
            ctrl.pc_source        = PCSRC_ALUOUT;
            ctrl.pc_write_cond_eq = (opcode == OP_BEQ);
            ctrl.pc_write_cond_ne = (opcode == OP_BNE);
            next_state            = ST_FETCH;
         end
         ST_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
            next_state     = ST_FETCH;
         end
         default: next_state = ST_FETCH;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register, reset gating of write strobes,
// and optional performance counters (enabled by MULTICYCLE_PERF_EN).
module multicycle_control
   import mc_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic [5:0]  opcode,
   input  logic        mem_ready,
   output logic        PCWrite,
   output logic        PCWriteCondEq,
   output logic        PCWriteCondNe,
   output logic        IorD,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic        MemToReg,
   output logic        RegDst,
   output logic        RegWrite,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ALUOp,
   output logic [1:0]  PCSource,
   output logic        illegal_op,
   output logic [31:0] cycle_count,
   output logic [31:0] instr_count
);

   state_t state;
   state_t next_state;
   ctrl_t  ctrl;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= ST_FETCH;
      else          state <= next_state;
   end

   mc_out_decode u_out_decode (
      .state      (state),
      .opcode     (opcode),
      .mem_ready  (mem_ready),
      .next_state (next_state),
      .ctrl       (ctrl)
   );

   // FETCH strobes follow mem_ready, so they must be masked while reset is held.
   assign PCWrite       = ctrl.pc_write         & reset_n;
   assign PCWriteCondEq = ctrl.pc_write_cond_eq & reset_n;
   assign PCWriteCondNe = ctrl.pc_write_cond_ne & reset_n;
   assign IRWrite       = ctrl.ir_write         & reset_n;
   assign RegWrite      = ctrl.reg_write        & reset_n;
   assign MemWrite      = ctrl.mem_write        & reset_n;
   assign illegal_op    = ctrl.illegal_op       & reset_n;
   assign IorD          = ctrl.i_or_d;
   assign MemRead       = ctrl.mem_read;
   assign MemToReg      = ctrl.mem_to_reg;
   assign RegDst        = ctrl.reg_dst;
   assign ALUSrcA       = ctrl.alu_src_a;
   assign ALUSrcB       = ctrl.alu_src_b;
   assign ALUOp         = ctrl.alu_op;
   assign PCSource      = ctrl.pc_source;

`ifdef MULTICYCLE_PERF_EN
   logic [31:0] cycle_q;
   logic [31:0] instr_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cycle_q <= '0;
         instr_q <= '0;
      end else begin
         cycle_q <= cycle_q + 32'd1;
         if (retires(state, mem_ready)) instr_q <= instr_q + 32'd1;
      end
   end

   assign cycle_count = cycle_q;
   assign instr_count = instr_q;
`else
   assign cycle_count = '0;
   assign instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: a per-instruction phase
// model pushes expected per-cycle outputs, a monitor pops and compares.
module tb_multicycle_control;

   localparam int CW = 18;
   localparam int W  = CW + 64;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [5:0]  opcode;
   logic        mem_ready;
   logic        PCWrite, PCWriteCondEq, PCWriteCondNe, IorD, MemRead, MemWrite;
   logic        IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA, illegal_op;
   logic [1:0]  ALUSrcB, ALUOp, PCSource;
   logic [31:0] cycle_count, instr_count;

   logic [W-1:0] exp_q[$];
   int           n_cmp = 0;
   int           n_bad = 0;
   logic [31:0]  m_cyc = 0;
   logic [31:0]  m_ins = 0;

   // Opcodes and mux encodings as the datapath sees them.
   localparam logic [5:0] LW = 6'h23, SW = 6'h2B, RT = 6'h00, BEQ = 6'h04;
   localparam logic [5:0] BNE = 6'h05, ADDI = 6'h08, JMP = 6'h02;

   multicycle_control dut (
      .clock(clock), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCondEq(PCWriteCondEq), .PCWriteCondNe(PCWriteCondNe),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .illegal_op(illegal_op),
      .cycle_count(cycle_count), .instr_count(instr_count)
   );

   always #5 clock = ~clock;

   function automatic logic [CW-1:0] cw(
      input bit pcw, input bit eq, input bit ne, input bit iord, input bit mr,
      input bit mw, input bit irw, input bit m2r, input bit rdst, input bit rw,
      input bit sa, input bit [1:0] sb, input bit [1:0] op, input bit [1:0] ps,
      input bit ill);
      return {pcw, eq, ne, iord, mr, mw, irw, m2r, rdst, rw, sa, sb, op, ps, ill};
   endfunction

   function automatic bit is_legal(input logic [5:0] op);
      return op == LW || op == SW || op == RT || op == BEQ || op == BNE ||
             op == ADDI || op == JMP;
   endfunction

   // One clock of stimulus: drive inputs, record what the outputs must be.
   task automatic tick(input logic [CW-1:0] w, input bit rdy,
                       input logic [5:0] op, input bit ret);
      mem_ready = rdy;
      opcode    = op;
`ifdef MULTICYCLE_PERF_EN
      exp_q.push_back({w, m_cyc, m_ins});
      m_cyc = m_cyc + 32'd1;
      if (ret) m_ins = m_ins + 32'd1;
`else
      exp_q.push_back({w, 64'h0});
`endif
      @(negedge clock);
   endtask

   task automatic reset_cycles(input int n);
      reset_n = 1'b0;
      m_cyc   = 0;
      m_ins   = 0;
      for (int i = 0; i < n; i++) begin
         mem_ready = 1'($urandom);
         opcode    = 6'($urandom);
         exp_q.push_back({cw(0,0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0), 64'h0});
         @(negedge clock);
      end
      reset_n = 1'b1;
   endtask

   // Phase sequence of one instruction; abort asserts reset after one
   // memory wait cycle and abandons the instruction.
   task automatic run_instr(input logic [5:0] opc, input int fw, input int mw,
                            input bit abort);
      bit is_sw;
      is_sw = (opc == SW);
      for (int i = 0; i < fw; i++)
         tick(cw(0,0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0), 1'b0, 6'($urandom), 0);
      tick(cw(1,0,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0), 1'b1, 6'($urandom), 0);
      tick(cw(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,!is_legal(opc)),
           1'($urandom), opc, 0);
      if (!is_legal(opc)) return;
      case (opc)
         LW, SW: begin
            tick(cw(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), 1'($urandom), opc, 0);
            for (int i = 0; i < mw; i++) begin
               tick(cw(0,0,0,1,!is_sw,is_sw,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b0, opc, 0);
               if (abort) begin
                  reset_cycles(1);
                  return;
               end
            end
            tick(cw(0,0,0,1,!is_sw,is_sw,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b1, opc, is_sw);
            if (!is_sw)
               tick(cw(0,0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0), 1'($urandom), opc, 1);
         end
         RT: begin
            tick(cw(0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0), 1'($urandom), opc, 0);
            tick(cw(0,0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0), 1'($urandom), opc, 1);
         end
         ADDI: begin
            tick(cw(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), 1'($urandom), opc, 0);
            tick(cw(0,0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0), 1'($urandom), opc, 1);
         end
         BEQ, BNE:
            tick(cw(0,opc == BEQ,opc == BNE,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0),
                 1'($urandom), opc, 1);
         default:
            tick(cw(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0), 1'($urandom), opc, 1);
      endcase
   endtask

   initial begin : monitor
      logic [W-1:0] exp_w;
      logic [W-1:0] act_w;
      forever begin
         @(negedge clock);
         #2;
         if (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            act_w = {PCWrite, PCWriteCondEq, PCWriteCondNe, IorD, MemRead, MemWrite,
                     IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                     PCSource, illegal_op, cycle_count, instr_count};
            n_cmp++;
            if (act_w !== exp_w) begin
               n_bad++;
               $display("FAIL ctrl_cycle t=%0t got ctrl=%h cyc=%0d ins=%0d want ctrl=%h cyc=%0d ins=%0d",
                        $time, act_w[W-1:64], act_w[63:32], act_w[31:0],
                        exp_w[W-1:64], exp_w[63:32], exp_w[31:0]);
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      logic [5:0] ops [7];
      logic [5:0] opc;
      int         mw;
      bit         ab;
      ops = '{RT, LW, SW, BEQ, BNE, ADDI, JMP};
      reset_n   = 1'b0;
      mem_ready = 1'b0;
      opcode    = 6'h00;
      @(negedge clock);
      reset_cycles(3);
      run_instr(LW, 0, 0, 0);
      run_instr(SW, 0, 3, 0);
      run_instr(BEQ, 0, 0, 0);
      run_instr(BNE, 0, 0, 0);
      run_instr(6'h3F, 0, 0, 0);
      run_instr(JMP, 2, 0, 0);
      run_instr(LW, 0, 2, 1);
      run_instr(RT, 0, 0, 0);
      run_instr(ADDI, 1, 0, 0);
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 7) == 0) opc = 6'($urandom);
         else                           opc = ops[$urandom_range(0, 6)];
         mw = $urandom_range(0, 3);
         ab = (opc == LW || opc == SW) && mw > 0 && $urandom_range(0, 15) == 0;
         run_instr(opc, $urandom_range(0, 2), mw, ab);
      end
      repeat (3) @(negedge clock);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL queue_drain: %0d entries left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
